// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: keeps a PC, drives the IMEM word address and presents
// the returned word to decode with a valid/ready handshake.
//
// Handshake: valid_o high means inst_o/pc_o hold a fetched instruction; it is
// accepted on an edge where valid_o and ready_i are both high. While not accepted,
// inst_o/pc_o stay stable unless a redirect replaces them on the next cycle.
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        ready_i,
    output logic [13:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        misalign_o,
    output logic [31:0] inst_cnt_o,
    output logic        dbg_state
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic [31:0] cnt_q;
    logic        misalign_q;
    logic        misalign_d;
    logic        handshake;

    // The IMEM is addressed with next_pc so the word arriving next cycle always
    // belongs to the pc_q loaded on the same edge: no bubbles, no tag matching.
    always_comb begin
        state_d    = state_q;
        next_pc    = pc_q;
        valid_o    = 1'b0;
        handshake  = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                next_pc = RESET_PC;
            end
            RUN: begin
                valid_o   = 1'b1;
                handshake = ready_i;
                if (redirect_i) begin
                    next_pc    = {redirect_pc_i[31:2], 2'b00};
                    misalign_d = |redirect_pc_i[1:0];
                end else if (ready_i) begin
                    next_pc = pc_q + 32'd4;
                end
            end
            default: begin
                state_d = BOOT;
                next_pc = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            cnt_q      <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= next_pc;
            misalign_q <= misalign_d;
            if (handshake) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Only word bits [15:2] reach the 64 KiB IMEM; higher PC bits alias.
    assign imem_addr_o = next_pc[15:2];
    assign inst_o      = imem_data_i;
    assign pc_o        = pc_q;
    assign misalign_o  = misalign_q;
    assign inst_cnt_o  = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/ama_riscv_fetch.md
AMA_RISCV_FETCH -- requirements
Module: ama_riscv_fetch

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 redirect_i  input  1  SHALL request a PC change (branch, jump or trap) when high.
REQ-006 redirect_pc_i  input  32  SHALL be the redirect target byte address.
REQ-007 ready_i  input  1  SHALL mean decode accepts the current instruction this cycle.
REQ-008 imem_addr_o  output  14  SHALL be the word address driven to the IMEM read port.
REQ-009 imem_data_i  input  32  SHALL be the IMEM read data, valid 1 cycle after the address.
REQ-010 valid_o  output  1  SHALL mean inst_o and pc_o hold a fetched instruction.
REQ-011 inst_o  output  32  SHALL be the fetched instruction, passed through from imem_data_i.
REQ-012 pc_o  output  32  SHALL be the byte address of inst_o.
REQ-013 misalign_o  output  1  SHALL be a one-cycle pulse that flags a redirect target with bits [1:0] nonzero.
REQ-014 inst_cnt_o  output  32  SHALL count completed handshakes (valid_o and ready_i both high).

Function
REQ-015 The FSM SHALL have 2 states: BOOT and RUN; reset SHALL force BOOT.
REQ-016 In BOOT: valid_o=0 and imem_addr_o=RESET_PC[15:2]. On the next edge: pc_q<=RESET_PC, and the state SHALL go to RUN.
REQ-017 In BOOT, redirect_i and ready_i SHALL be ignored.
REQ-018 In RUN: valid_o=1, inst_o=imem_data_i, pc_o=pc_q.
REQ-019 In RUN, next_pc SHALL be computed by priority:
 - redirect_i: {redirect_pc_i[31:2],2'b00}
 - else ready_i: pc_q+4 (32-bit, wraps modulo 2^32)
 - else: pc_q
REQ-020 In RUN, imem_addr_o SHALL equal next_pc[15:2] combinationally, and pc_q<=next_pc every edge, so inst_o always matches pc_o with zero bubbles.
REQ-021 Hold (valid_o=1, ready_i=0, no redirect) SHALL re-present pc_q[15:2] so inst_o and pc_o stay stable until accepted.
REQ-022 Redirect SHALL have 1-cycle latency: the cycle after redirect_i, pc_o is the target and inst_o is mem[target].
REQ-023 Redirect SHALL take priority over a concurrent hold or handshake. The instruction shown in the redirect cycle SHALL be counted only if ready_i=1.
REQ-024 Back-to-back redirects SHALL each take effect; only the last target is fetched.
REQ-025 A redirect with redirect_pc_i[1:0]!=0 SHALL clear those bits for the fetch and SHALL assert misalign_o for exactly the next cycle.
REQ-026 Addresses above 64 KiB SHALL alias: only pc bits [15:2] reach imem_addr_o, while pc_o keeps all 32 bits.
REQ-027 inst_cnt_o SHALL increment by 1 per handshake and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 The fetch path SHALL tolerate arbitrary ready_i patterns with no lost or duplicated instruction.

Reset
REQ-029 Asserting rst_n low SHALL immediately (asynchronously), including mid-hold or mid-redirect, set:
 - state BOOT, valid_o=0, pc_q=RESET_PC, misalign_o=0, inst_cnt_o=0
 - imem_addr_o=RESET_PC[15:2]
REQ-030 After rst_n deasserts, the first valid_o=1 SHALL appear one edge later, with pc_o=RESET_PC.

Verification
REQ-031 Reset release, ready_i=1, IMEM preloaded with word k = k -> pc_o 0,4,8,... with inst_o 0,1,2,...; inst_cnt_o=3 after 3 accepted cycles.
REQ-032 Hold: ready_i=0 for 3 cycles at pc 0x8 -> pc_o=0x8 and inst_o=2 stable; imem_addr_o=2; no count change.
REQ-033 Redirect to 0x100 while ready_i=0 -> next cycle pc_o=0x100, inst_o=mem[0x40]; held instruction not counted.
REQ-034 Redirect to 0x103 -> pc_o=0x100 next cycle, and misalign_o high for exactly that one cycle.
REQ-035 Reset asserted mid-run at pc 0x40 -> valid_o=0 and inst_cnt_o=0 with no clock; after release pc_o=RESET_PC.
REQ-036 Counter preset near wrap (forced to FFFF_FFFE) plus 3 handshakes -> inst_cnt_o=1; pc wrap from 0xFFFF_FFFC -> pc_o 0x0, imem_addr_o=0.
